// File: rtl/alu_seq_ctrl.sv
// Multi-cycle 64-bit ALU controller: processes SLICE_W bits per clock with a
// ripple carry between slices, then presents the result with a valid/ready handshake.
module alu_seq_ctrl #(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ifun,
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        out_err,
    output logic [2:0]  cc
);

    localparam int NSLICE = 64 / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [3:0]         ifun_reg;
    logic [63:0]        a_reg;
    logic [63:0]        b_reg;
    logic [63:0]        acc_reg;
    logic [63:0]        val_e_reg;
    logic               out_valid_reg;
    logic               out_err_reg;
    logic [2:0]         cc_reg;

    logic [SLICE_W-1:0] a_sl [NSLICE];
    logic [SLICE_W-1:0] b_sl [NSLICE];
    logic [SLICE_W-1:0] a_cur;
    logic [SLICE_W-1:0] b_cur;
    logic [SLICE_W-1:0] a_op;
    logic [SLICE_W:0]   sum_next;
    logic               cin;
    logic [SLICE_W-1:0] slice_next;
    logic               carry_next;
    logic [63:0]        acc_next;
    logic [63:0]        res_final;
    logic [2:0]         cc_next;
    logic               op_add;
    logic               op_sub;
    logic               op_legal;
    logic               last_slice;
    logic               of_add;
    logic               of_sub;

    assign op_add     = (ifun_reg == 4'd0);
    assign op_sub     = (ifun_reg == 4'd1);
    assign op_legal   = (ifun_reg <= 4'd3);
    assign last_slice = (cnt_reg == LAST_CNT);

    // Slice views of the latched operands, and the accumulator with the
    // slice currently being computed merged in at position cnt.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign acc_next[gi*SLICE_W +: SLICE_W] =
                (cnt_reg == CNT_W'(gi)) ? slice_next : acc_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign a_cur = a_sl[cnt_reg];
    assign b_cur = b_sl[cnt_reg];

    // Subtraction is B + ~A + 1: the +1 enters as carry-in on slice 0 only.
    always_comb begin
        a_op       = op_sub ? ~a_cur : a_cur;
        cin        = (op_sub && (cnt_reg == '0)) ? 1'b1 : carry_reg;
        sum_next   = {1'b0, b_cur} + {1'b0, a_op} + {{SLICE_W{1'b0}}, cin};
        carry_next = sum_next[SLICE_W];
        case (ifun_reg)
            4'd0, 4'd1: slice_next = sum_next[SLICE_W-1:0];
            4'd2:       slice_next = b_cur & a_cur;
            4'd3:       slice_next = b_cur ^ a_cur;
            default:    slice_next = '0;
        endcase
    end

    always_comb begin
        res_final = op_legal ? acc_next : 64'd0;
        of_add    = (a_reg[63] == b_reg[63]) && (acc_next[63] != a_reg[63]);
        of_sub    = (a_reg[63] != b_reg[63]) && (acc_next[63] != b_reg[63]);
        cc_next   = {(acc_next == 64'd0), acc_next[63],
                     (op_add && of_add) || (op_sub && of_sub)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            ifun_reg      <= 4'd0;
            a_reg         <= 64'd0;
            b_reg         <= 64'd0;
            acc_reg       <= 64'd0;
            val_e_reg     <= 64'd0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            cc_reg        <= 3'b100;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && !flush) begin
                        ifun_reg  <= ifun;
                        a_reg     <= aluA;
                        b_reg     <= aluB;
                        carry_reg <= 1'b0;
                        acc_reg   <= 64'd0;
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= '0;
                        out_valid_reg <= 1'b0;
                    end else begin
                        acc_reg   <= acc_next;
                        carry_reg <= carry_next;
                        if (last_slice) begin
                            cnt_reg       <= '0;
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            val_e_reg     <= res_final;
                            out_err_reg   <= !op_legal;
                            if (op_legal) begin
                                cc_reg <= cc_next;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // flush and out_ready both retire the result; neither accepts a new op this edge
                    if (flush || out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !flush;
    assign out_valid = out_valid_reg;
    assign valE      = val_e_reg;
    assign out_err   = out_err_reg;
    assign cc        = cc_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and handshake/flush/reset sequences.
module tb_alu_seq_ctrl;

    localparam int NSLICE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ifun;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        out_err;
    logic [2:0]  cc;

    int checks = 0;
    int errors = 0;
    logic [2:0] cc_model;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.SLICE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifun      (ifun),
        .aluA      (aluA),
        .aluB      (aluB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valE      (valE),
        .out_err   (out_err),
        .cc        (cc)
    );

    typedef struct {
        logic [3:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] v;
        logic        e;
        logic [2:0]  c;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic and the flag rules, no slicing.
    function automatic void ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] cc_prev, output logic [63:0] v,
                                   output logic err, output logic [2:0] c);
        logic of;
        of  = 1'b0;
        err = 1'b0;
        v   = 64'd0;
        case (f)
            4'd0: begin v = b + a; of = (a[63] == b[63]) && (v[63] != a[63]); end
            4'd1: begin v = b - a; of = (a[63] != b[63]) && (v[63] != b[63]); end
            4'd2: v = b & a;
            4'd3: v = b ^ a;
            default: err = 1'b1;
        endcase
        c = err ? cc_prev : {(v == 64'd0), v[63], of};
    endfunction

    // Called just after the acceptance edge; counts edges until out_valid.
    task automatic wait_result(input string tag, input logic [63:0] ev, input logic ee, input logic [2:0] ec);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < 16 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) seen = 1;
        end
        check({tag, " latency"}, 64'(n), 64'(NSLICE));
        if (seen) begin
            check({tag, " valE"}, valE, ev);
            check({tag, " out_err"}, out_err, ee);
            check({tag, " cc"}, cc, ec);
        end
        $display("op %s: valE=%h err=%0d cc=%b latency=%0d", tag, valE, out_err, cc, n);
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ev, input logic ee, input logic [2:0] ec);
        check({tag, " in_ready"}, in_ready, 1);
        ifun = f;
        aluA = a;
        aluB = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ifun = 4'($urandom);
        aluA = {$urandom, $urandom};
        aluB = {$urandom, $urandom};
        wait_result(tag, ev, ee, ec);
    endtask

    task automatic ret_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, " ret out_valid"}, out_valid, 0);
        check({tag, " ret in_ready"}, in_ready, 1);
    endtask

    task automatic no_output(input string tag);
        int seen_cnt;
        seen_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_cnt++;
        end
        check({tag, " no out_valid"}, 64'(seen_cnt), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        logic        e;
        logic [2:0]  c;
        logic [3:0]  f;
        logic [63:0] a;
        logic [63:0] b;

        tbl[0] = '{4'd0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
        tbl[1] = '{4'd1, 64'h5, 64'h5, 64'h0, 1'b0, 3'b100};
        tbl[2] = '{4'd1, 64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010};
        tbl[3] = '{4'd3, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 3'b010};
        tbl[4] = '{4'd2, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 1'b0, 3'b000};
        tbl[5] = '{4'd7, 64'h123, 64'h456, 64'h0, 1'b1, 3'b000};

        rst = 1'b1;
        in_valid = 1'b0;
        ifun = 4'd0;
        aluA = 64'd0;
        aluB = 64'd0;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset valE", valE, 64'd0);
        check("reset out_valid", out_valid, 0);
        check("reset out_err", out_err, 0);
        check("reset cc", cc, 3'b100);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        cc_model = 3'b100;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].e, tbl[i].c);
            cc_model = tbl[i].c;
            ret_idle($sformatf("vec%0d", i));
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 7 == 0) a = 64'h8000_0000_0000_0000;
            if (i % 5 == 0) b = a;
            ref_op(f, a, b, cc_model, v, e, c);
            run_op($sformatf("rnd%0d", i), f, a, b, v, e, c);
            cc_model = c;
            ret_idle($sformatf("rnd%0d", i));
        end

        // Consumer stall in DONE with a pending request held high
        out_ready = 1'b0;
        ref_op(4'd0, 64'd3, 64'd4, cc_model, v, e, c);
        run_op("hold", 4'd0, 64'd3, 64'd4, v, e, c);
        cc_model = c;
        ifun = 4'd1;
        aluA = 64'd10;
        aluB = 64'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d out_valid", k), out_valid, 1);
            check($sformatf("hold%0d valE", k), valE, 64'd7);
            check($sformatf("hold%0d in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold release out_valid", out_valid, 0);
        check("hold release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("hold accept in_ready", in_ready, 0);
        in_valid = 1'b0;
        ref_op(4'd1, 64'd10, 64'd3, cc_model, v, e, c);
        wait_result("hold_next", v, e, c);
        cc_model = c;
        ret_idle("hold_next");

        // Flush during the second BUSY cycle
        ifun = 4'd0;
        aluA = 64'd1;
        aluB = 64'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush busy out_valid", out_valid, 0);
        check("flush busy cc", cc, cc_model);
        flush = 1'b0;
        #1;
        check("flush busy in_ready", in_ready, 1);
        no_output("flush busy");

        // Flush in IDLE blocks acceptance only
        ifun = 4'd0;
        aluA = 64'd2;
        aluB = 64'd2;
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush idle in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush idle not accepted", in_ready, 1);
        no_output("flush idle");

        // Flush in DONE discards the result
        out_ready = 1'b0;
        ref_op(4'd2, 64'hF, 64'h3, cc_model, v, e, c);
        run_op("flush_done", 4'd2, 64'hF, 64'h3, v, e, c);
        cc_model = c;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush done out_valid", out_valid, 0);
        check("flush done cc", cc, cc_model);
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush done in_ready", in_ready, 1);

        // Asynchronous reset mid-BUSY
        ifun = 4'd0;
        aluA = 64'd7;
        aluB = 64'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst busy out_valid", out_valid, 0);
        check("rst busy cc", cc, 3'b100);
        check("rst busy valE", valE, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst busy in_ready", in_ready, 1);
        cc_model = 3'b100;
        no_output("rst busy");

        ref_op(4'd1, 64'h10, 64'h8, cc_model, v, e, c);
        run_op("post_rst", 4'd1, 64'h10, 64'h8, v, e, c);
        cc_model = c;
        ret_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter: SLICE_W, 16, bits processed per cycle; legal values 8, 16, 32, 64; NSLICE = 64/SLICE_W.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: ifun  input  4  function code: 0 add, 1 sub, 2 and, 3 xor, others illegal.
REQ-007 SHALL have port: aluA  input  64  operand A.
REQ-008 SHALL have port: aluB  input  64  operand B.
REQ-009 SHALL have port: flush  input  1  synchronous abort of the current operation.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port: valE  output  64  result.
REQ-013 SHALL have port: out_err  output  1  completed op had an illegal ifun.
REQ-014 SHALL have port: cc  output  3  condition codes {ZF,SF,OF}.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE; slice counter cnt counts 0..NSLICE-1.
REQ-016 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-017 Accept on edge with in_valid&in_ready: latch ifun, aluA, aluB; clear carry and valE; cnt=0; go BUSY.
REQ-018 In BUSY, each edge SHALL compute slice cnt (bits cnt*SLICE_W+SLICE_W-1 : cnt*SLICE_W) into valE and update carry, then increment cnt.
REQ-019 Ops: add valE=aluB+aluA; sub valE=aluB-aluA (aluB + ~aluA, carry-in 1 on slice 0); and valE=aluB&aluA; xor valE=aluB^aluA; all modulo 2^64.
REQ-020 On the edge processing slice NSLICE-1, state SHALL go DONE; out_valid rises exactly NSLICE edges after acceptance (4 for SLICE_W=16).
REQ-021 At DONE entry cc SHALL update: ZF=(valE==0), SF=valE[63]; OF for add = (A[63]==B[63])&&(valE[63]!=A[63]); OF for sub = (A[63]!=B[63])&&(valE[63]!=B[63]); OF=0 for and/xor.
REQ-022 Illegal ifun: SHALL complete with same latency, valE=0, out_err=1, cc unchanged.
REQ-023 out_valid=1 only in DONE; valE, out_err, out_valid SHALL hold stable until out_ready=1.
REQ-024 DONE with out_ready=1: go IDLE next edge; no back-to-back acceptance in the same edge.
REQ-025 valE SHALL hold last completed result in IDLE; partial values visible in BUSY are undefined to consumers.
REQ-026 flush=1 in BUSY or DONE: go IDLE next edge, out_valid=0, cc unchanged, result discarded; flush has priority over in_valid and out_ready.
REQ-027 flush in IDLE SHALL block acceptance that cycle and have no other effect.
REQ-028 Inputs aluA, aluB, ifun SHALL be ignored outside the acceptance edge.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, cnt=0, carry=0, valE=0, out_valid=0, out_err=0, cc=3'b100 (ZF=1,SF=0,OF=0).
REQ-030 rst asserted mid-BUSY or in DONE SHALL discard the operation; in_ready=1 on the first edge after release.

Verification
REQ-031 Reset then add A=1, B=0x7FFFFFFFFFFFFFFF, out_ready=1 -> out_valid at 4th edge, valE=0x8000000000000000, cc=3'b011.
REQ-032 sub A=5, B=5 -> valE=0, cc=3'b100; sub A=1, B=0 -> valE=0xFFFFFFFFFFFFFFFF, cc=3'b010.
REQ-033 xor A=0xFFFF0000FFFF0000, B=0x0F0F0F0F0F0F0F0F -> valE=0xF0F00F0FF0F00F0F, cc=3'b010; and same operands -> valE=0x0F0F00000F0F0000, cc=3'b000.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid, valE stable, in_ready=0 throughout; in_valid held high is accepted only after the IDLE return.
REQ-035 flush at 2nd BUSY cycle, then rst pulse mid-BUSY of a new op -> no out_valid, cc unchanged by flush, cc=3'b100 after rst.
REQ-036 ifun=7 -> out_valid after 4 edges, valE=0, out_err=1, cc unchanged.
